// File: rtl/vball_pkg.sv
// Shared types and helpers for the vertical ball controller.
// Holds the state encoding, the speed code type and the paddle segment map.
package vball_pkg;

    typedef enum logic [1:0] {
        ATTRACT_S = 2'd0,
        SERVE_S   = 2'd1,
        PLAY_S    = 2'd2,
        MISS_S    = 2'd3
    } vball_state_t;

    // {dir, mag[1:0]}: dir = 1 moves the ball up, mag is lines added per frame
    typedef logic [2:0] spd_code_t;

    localparam spd_code_t SPD_STILL = 3'b000;

    // Upper paddle segments deflect upward, the middle returns flat, lower deflect downward
    function automatic spd_code_t seg_to_spd(input logic [3:0] seg);
        spd_code_t code;
        case (seg)
            4'd0, 4'd1:               code = 3'b111;
            4'd2, 4'd3:               code = 3'b110;
            4'd4, 4'd5:               code = 3'b101;
            4'd6, 4'd7, 4'd8, 4'd9:   code = 3'b000;
            4'd10, 4'd11:             code = 3'b001;
            4'd12, 4'd13:             code = 3'b010;
            default:                  code = 3'b011;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Per-bit rising/falling edge detector for level inputs sampled on clk.
// One prev register per bit; outputs are combinational from input and prev.
module edge_det #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x_i,
    output logic [N-1:0] rise_o,
    output logic [N-1:0] fall_o
);

    logic [N-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= x_i;
        end
    end

    assign rise_o = x_i & ~prev_q;
    assign fall_o = ~x_i & prev_q;

endmodule

// File: rtl/vball_ctrl.sv
// Vertical ball sequencing controller: paddle hits set per-side speed codes,
// walls flip direction, and the attract/serve/miss sequence freezes or reloads them.
module vball_ctrl
    import vball_pkg::*;
#(
    parameter logic [5:0] SERVE_FRAMES = 6'd32,
    parameter logic [5:0] MISS_FRAMES  = 6'd48,
    parameter spd_code_t  SERVE_VEC    = 3'b001
) (
    input  logic       CLK_DRV,
    input  logic       RESET,
    input  logic       ATTRACT,
    input  logic       HIT_L,
    input  logic       HIT_R,
    input  logic [3:0] PAD_SEG,
    input  logic       WALL,
    input  logic       MISS,
    input  logic       VBLANK,
    output logic [2:0] SPD_L,
    output logic [2:0] SPD_R,
    output logic       SERVE,
    output logic       FREEZE,
    output logic [1:0] STATE
);

    logic [4:0]   rise;
    logic [4:0]   fall;
    logic         edge_unused;

    vball_state_t state_q;
    spd_code_t    spd_l_q;
    spd_code_t    spd_r_q;
    logic         serve_q;
    logic         freeze_q;
    logic [5:0]   cnt_q;

    logic         fr;
    logic         hit_l_r;
    logic         hit_r_r;
    logic         wall_r;
    logic         miss_r;
    spd_code_t    seg_code;

    // Bit order: 0 VBLANK, 1 HIT_L, 2 HIT_R, 3 WALL, 4 MISS
    edge_det #(.N(5)) u_edge (
        .clk    (CLK_DRV),
        .rst    (RESET),
        .x_i    ({MISS, WALL, HIT_R, HIT_L, VBLANK}),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign fr          = fall[0];
    assign hit_l_r     = rise[1];
    assign hit_r_r     = rise[2];
    assign wall_r      = rise[3];
    assign miss_r      = rise[4];
    assign edge_unused = ^{rise[0], fall[4:1]};
    assign seg_code    = seg_to_spd(PAD_SEG);

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            state_q  <= ATTRACT_S;
            spd_l_q  <= SPD_STILL;
            spd_r_q  <= SPD_STILL;
            serve_q  <= 1'b0;
            freeze_q <= 1'b1;
            cnt_q    <= '0;
        end else if (ATTRACT) begin
            state_q  <= ATTRACT_S;
            spd_l_q  <= SPD_STILL;
            spd_r_q  <= SPD_STILL;
            serve_q  <= 1'b0;
            freeze_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ATTRACT_S: begin
                    state_q  <= SERVE_S;
                    spd_l_q  <= SERVE_VEC;
                    spd_r_q  <= SERVE_VEC;
                    serve_q  <= 1'b1;
                    freeze_q <= 1'b0;
                    cnt_q    <= '0;
                end
                SERVE_S: begin
                    if (fr) begin
                        if (cnt_q == SERVE_FRAMES - 6'd1) begin
                            state_q <= PLAY_S;
                            serve_q <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                PLAY_S: begin
                    // A miss swallows any hit or wall seen in the same cycle
                    if (miss_r) begin
                        state_q  <= MISS_S;
                        freeze_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        if (hit_l_r) begin
                            spd_l_q <= seg_code;
                        end else if (wall_r) begin
                            spd_l_q <= {~spd_l_q[2], spd_l_q[1:0]};
                        end
                        if (hit_r_r) begin
                            spd_r_q <= seg_code;
                        end else if (wall_r) begin
                            spd_r_q <= {~spd_r_q[2], spd_r_q[1:0]};
                        end
                    end
                end
                MISS_S: begin
                    if (fr) begin
                        if (cnt_q == MISS_FRAMES - 6'd1) begin
                            state_q  <= SERVE_S;
                            spd_l_q  <= SERVE_VEC;
                            spd_r_q  <= SERVE_VEC;
                            serve_q  <= 1'b1;
                            freeze_q <= 1'b0;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ATTRACT_S;
                end
            endcase
        end
    end

    assign SPD_L  = spd_l_q;
    assign SPD_R  = spd_r_q;
    assign SERVE  = serve_q;
    assign FREEZE = freeze_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_vball_ctrl.sv
// Directed bench for vball_ctrl: walks attract, serve, play, miss and reset
// with hand-computed expected codes and states.
module tb_vball_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       attract;
    logic       hit_l;
    logic       hit_r;
    logic [3:0] pad_seg;
    logic       wall;
    logic       miss;
    logic       vblank;
    logic [2:0] spd_l;
    logic [2:0] spd_r;
    logic       serve;
    logic       freeze;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    vball_ctrl dut (
        .CLK_DRV (clk),
        .RESET   (rst),
        .ATTRACT (attract),
        .HIT_L   (hit_l),
        .HIT_R   (hit_r),
        .PAD_SEG (pad_seg),
        .WALL    (wall),
        .MISS    (miss),
        .VBLANK  (vblank),
        .SPD_L   (spd_l),
        .SPD_R   (spd_r),
        .SERVE   (serve),
        .FREEZE  (freeze),
        .STATE   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1;
            step();
            vblank = 1'b0;
            step();
        end
    endtask

    task automatic hit(input logic left, input logic right, input logic [3:0] seg);
        pad_seg = seg;
        hit_l   = left;
        hit_r   = right;
        step();
        hit_l   = 1'b0;
        hit_r   = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; attract = 1'b1; hit_l = 1'b0; hit_r = 1'b0;
        pad_seg = 4'd0; wall = 1'b0; miss = 1'b0; vblank = 1'b0;
        step(2);
        check("rst_state",  8'(state),  8'd0);
        check("rst_spd",    8'({spd_l, spd_r}), 8'h00);
        check("rst_flags",  8'({serve, freeze}), 8'b01);

        rst = 1'b0;
        step(2);
        check("attract_hold", 8'(state), 8'd0);

        // Serve entry and frame count
        attract = 1'b0;
        step();
        check("serve_state", 8'(state), 8'd1);
        check("serve_flags", 8'({serve, freeze}), 8'b10);
        check("serve_spd",   8'({spd_l, spd_r}), 8'b001_001);
        frames(31);
        check("serve_31fr",  8'(state), 8'd1);
        frames(1);
        check("play_state",  8'(state), 8'd2);
        check("play_serve",  8'(serve), 8'd0);

        // Segment map, left side only
        hit(1'b1, 1'b0, 4'd1);
        check("seg1_l", 8'(spd_l), 8'b111);
        check("seg1_r", 8'(spd_r), 8'b001);
        hit(1'b1, 1'b0, 4'd7);
        check("seg7_l", 8'(spd_l), 8'b000);
        hit(1'b1, 1'b0, 4'd11);
        check("seg11_l", 8'(spd_l), 8'b001);
        pad_seg = 4'd15; hit_l = 1'b1;
        step();
        check("seg15_l", 8'(spd_l), 8'b011);
        pad_seg = 4'd0;
        step(3);
        check("hit_held", 8'(spd_l), 8'b011);
        hit_l = 1'b0;
        step();

        // Wall flips both, held level flips once
        hit(1'b1, 1'b0, 4'd4);
        hit(1'b0, 1'b1, 4'd12);
        check("pre_wall", 8'({spd_l, spd_r}), 8'b101_010);
        wall = 1'b1;
        step();
        check("wall_flip", 8'({spd_l, spd_r}), 8'b001_110);
        step(10);
        check("wall_held", 8'({spd_l, spd_r}), 8'b001_110);
        wall = 1'b0;
        step();

        // Wall with right hit: right takes the map, left still flips
        wall = 1'b1; hit_r = 1'b1; pad_seg = 4'd3;
        step();
        check("wall_hitr", 8'({spd_l, spd_r}), 8'b101_110);
        wall = 1'b0; hit_r = 1'b0;
        step();

        // Both hits together use the same segment
        hit(1'b1, 1'b1, 4'd13);
        check("both_hits", 8'({spd_l, spd_r}), 8'b010_010);
        hit(1'b0, 1'b1, 4'd2);

        // Miss beats a same-cycle hit
        miss = 1'b1; hit_l = 1'b1; pad_seg = 4'd9;
        step();
        check("miss_state", 8'(state), 8'd3);
        check("miss_flags", 8'({serve, freeze}), 8'b01);
        check("miss_codes", 8'({spd_l, spd_r}), 8'b010_110);
        miss = 1'b0; hit_l = 1'b0;
        frames(47);
        check("miss_47fr", 8'(state), 8'd3);
        frames(1);
        check("reserve_state", 8'(state), 8'd1);
        check("reserve_spd",   8'({spd_l, spd_r}), 8'b001_001);

        // Hits and walls ignored during serve
        hit(1'b1, 1'b0, 4'd0);
        wall = 1'b1;
        step();
        wall = 1'b0;
        step();
        check("serve_ignore", 8'({spd_l, spd_r}), 8'b001_001);

        // Attract from MISS_S
        frames(32);
        check("play2_state", 8'(state), 8'd2);
        miss = 1'b1;
        step();
        miss = 1'b0;
        check("miss2_state", 8'(state), 8'd3);
        attract = 1'b1;
        step();
        check("attr_state", 8'(state), 8'd0);
        check("attr_spd",   8'({spd_l, spd_r}), 8'h00);
        check("attr_flags", 8'({serve, freeze}), 8'b01);

        // Async reset mid-play
        attract = 1'b0;
        step();
        frames(32);
        hit(1'b1, 1'b0, 4'd2);
        check("pre_rst_l", 8'(spd_l), 8'b110);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_spd",   8'({spd_l, spd_r}), 8'h00);
        check("arst_state", 8'(state), 8'd0);
        check("arst_flags", 8'({serve, freeze}), 8'b01);
        rst = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
